// File: rtl/pvr_param_pkg.sv
// Shared PowerVR parameter-format definitions: ISP_INST field positions,
// writer state encoding and vertex layout helpers used by isp_param_writer.
package pvr_param_pkg;

  localparam int unsigned ISP_TEXTURE_BIT = 25;
  localparam int unsigned ISP_OFFSET_BIT  = 24;
  localparam int unsigned ISP_UV16_BIT    = 22;
  localparam int unsigned WORD_W          = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_VWAIT,
    ST_VX,
    ST_VY,
    ST_VZ,
    ST_VU,
    ST_VV,
    ST_VCOL,
    ST_VOFF,
    ST_DONE
  } pw_state_e;

  typedef struct packed {
    logic texture;
    logic offset;
    logic uv16;
  } isp_fmt_t;

  typedef struct packed {
    logic [WORD_W-1:0] isp;
    logic [WORD_W-1:0] tsp;
    logic [WORD_W-1:0] tex;
  } poly_hdr_t;

  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] z;
    logic [WORD_W-1:0] u0;
    logic [WORD_W-1:0] v0;
    logic [WORD_W-1:0] base_col;
    logic [WORD_W-1:0] off_col;
  } vertex_t;

  function automatic isp_fmt_t decode_fmt(input logic [WORD_W-1:0] isp_inst);
    isp_fmt_t f;
    f.texture = isp_inst[ISP_TEXTURE_BIT];
    f.offset  = isp_inst[ISP_OFFSET_BIT];
    f.uv16    = isp_inst[ISP_UV16_BIT];
    return f;
  endfunction

  function automatic logic [3:0] words_per_vertex(input isp_fmt_t f);
    logic [3:0] n;
    n = 4'd4;
    if (f.texture) n = n + (f.uv16 ? 4'd1 : 4'd2);
    if (f.offset)  n = n + 4'd1;
    return n;
  endfunction

  // Successor of a vertex word state; ST_VWAIT marks the end of the vertex.
  function automatic pw_state_e next_vword(input pw_state_e s, input isp_fmt_t f);
    case (s)
      ST_VX:   return ST_VY;
      ST_VY:   return ST_VZ;
      ST_VZ:   return f.texture ? ST_VU : ST_VCOL;
      ST_VU:   return f.uv16 ? ST_VCOL : ST_VV;
      ST_VV:   return ST_VCOL;
      ST_VCOL: return f.offset ? ST_VOFF : ST_VWAIT;
      default: return ST_VWAIT;
    endcase
  endfunction

endpackage

// File: rtl/isp_param_writer.sv
// Streams one ISP polygon (3 header words plus a vertex strip) into VRAM,
// pulling each vertex through a ready/valid handshake.
module isp_param_writer
  import pvr_param_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       isp_inst,
  input  logic [31:0]       tsp_inst,
  input  logic [31:0]       tex_cont,
  input  logic [3:0]        vert_count,
  input  logic              vert_valid,
  input  logic [31:0]       vert_x,
  input  logic [31:0]       vert_y,
  input  logic [31:0]       vert_z,
  input  logic [31:0]       vert_u0,
  input  logic [31:0]       vert_v0,
  input  logic [31:0]       vert_base_col,
  input  logic [31:0]       vert_off_col,
  output logic              vert_ready,
  output logic              isp_vram_wr,
  output logic [ADDR_W-1:0] isp_vram_addr,
  output logic [31:0]       isp_vram_dout,
  input  logic              isp_vram_wait,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] end_addr
);

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  pw_state_e         state_q, state_d;
  poly_hdr_t         hdr_q, hdr_d;
  isp_fmt_t          fmt_q, fmt_d;
  vertex_t           vert_q, vert_d;
  logic [3:0]        vcount_q, vcount_d;
  logic [3:0]        vidx_q, vidx_d;
  logic              wr_q, wr_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dout_q, dout_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic              accept;
  pw_state_e         vword_nxt;

  // Data word presented for a given state, taken from the post-capture values.
  function automatic logic [31:0] word_sel(input pw_state_e s, input poly_hdr_t h,
                                           input vertex_t v, input logic [31:0] hold);
    case (s)
      ST_HDR0: return h.isp;
      ST_HDR1: return h.tsp;
      ST_HDR2: return h.tex;
      ST_VX:   return v.x;
      ST_VY:   return v.y;
      ST_VZ:   return v.z;
      ST_VU:   return v.u0;
      ST_VV:   return v.v0;
      ST_VCOL: return v.base_col;
      ST_VOFF: return v.off_col;
      default: return hold;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    fmt_d      = fmt_q;
    vert_d     = vert_q;
    vcount_d   = vcount_q;
    vidx_d     = vidx_q;
    addr_d     = addr_q;
    end_addr_d = end_addr_q;
    accept     = wr_q & ~isp_vram_wait;
    vword_nxt  = next_vword(state_q, fmt_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hdr_d    = '{isp: isp_inst, tsp: tsp_inst, tex: tex_cont};
          fmt_d    = decode_fmt(isp_inst);
          vcount_d = (vert_count < 4'd3) ? 4'd3 : vert_count;
          vidx_d   = 4'd0;
          addr_d   = base_addr;
          state_d  = ST_HDR0;
        end
      end
      ST_HDR0, ST_HDR1, ST_HDR2: begin
        if (accept) begin
          addr_d = addr_q + WORD_BYTES;
          case (state_q)
            ST_HDR0: state_d = ST_HDR1;
            ST_HDR1: state_d = ST_HDR2;
            default: state_d = ST_VWAIT;
          endcase
        end
      end
      ST_VWAIT: begin
        if (vert_valid) begin
          vert_d  = '{x: vert_x, y: vert_y, z: vert_z, u0: vert_u0, v0: vert_v0,
                      base_col: vert_base_col, off_col: vert_off_col};
          state_d = ST_VX;
        end
      end
      ST_VX, ST_VY, ST_VZ, ST_VU, ST_VV, ST_VCOL, ST_VOFF: begin
        if (accept) begin
          addr_d = addr_q + WORD_BYTES;
          if (vword_nxt != ST_VWAIT) begin
            state_d = vword_nxt;
          end else if (vidx_q == vcount_q - 4'd1) begin
            end_addr_d = addr_q + WORD_BYTES;
            state_d    = ST_DONE;
          end else begin
            vidx_d  = vidx_q + 4'd1;
            state_d = ST_VWAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of the decode of the next state.
    wr_d    = state_d inside {ST_HDR0, ST_HDR1, ST_HDR2, ST_VX, ST_VY, ST_VZ,
                              ST_VU, ST_VV, ST_VCOL, ST_VOFF};
    ready_d = (state_d == ST_VWAIT);
    busy_d  = !(state_d inside {ST_IDLE, ST_DONE});
    done_d  = (state_d == ST_DONE);
    dout_d  = word_sel(state_d, hdr_d, vert_d, dout_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hdr_q      <= '0;
      fmt_q      <= '0;
      vert_q     <= '0;
      vcount_q   <= 4'd3;
      vidx_q     <= '0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      end_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      fmt_q      <= fmt_d;
      vert_q     <= vert_d;
      vcount_q   <= vcount_d;
      vidx_q     <= vidx_d;
      wr_q       <= wr_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      end_addr_q <= end_addr_d;
    end
  end

  assign isp_vram_wr   = wr_q;
  assign vert_ready    = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign isp_vram_addr = addr_q;
  assign isp_vram_dout = dout_q;
  assign end_addr      = end_addr_q;

endmodule

// File: doc/isp_param_writer.md
ISP_PARAM_WRITER -- requirements
Module: isp_param_writer

Interface
REQ-001 Parameter ADDR_W, default 24, VRAM byte-address width.
REQ-002 clock  in  1  sole clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle request to write one polygon; sampled only in IDLE.
REQ-005 base_addr  in  ADDR_W  first word address, word-aligned; captured on accepted start.
REQ-006 isp_inst, tsp_inst, tex_cont  in  32 each  header words; captured on accepted start.
REQ-007 vert_count  in  4  vertices in strip; captured on accepted start; values 0..2 treated as 3.
REQ-008 vert_valid  in  1  vertex fields valid.
REQ-009 vert_x, vert_y, vert_z, vert_u0, vert_v0, vert_base_col, vert_off_col  in  32 each  vertex fields.
REQ-010 vert_ready  out  1  writer accepts vertex this cycle.
REQ-011 isp_vram_wr  out  1  write request.
REQ-012 isp_vram_addr  out  ADDR_W  write byte address.
REQ-013 isp_vram_dout  out  32  write data.
REQ-014 isp_vram_wait  in  1  VRAM stall; word accepted when isp_vram_wr=1 and isp_vram_wait=0.
REQ-015 busy  out  1  high from accepted start until done.
REQ-016 done  out  1  one-cycle pulse after final word accepted.
REQ-017 end_addr  out  ADDR_W  address following last written word; valid from done until next start.

Function
REQ-018 Format decoded from captured isp_inst: texture=bit25, offset=bit24, uv_16_bit=bit22; bits 31:26 and two-volume/shadow not used.
REQ-019 Word order: isp_inst, tsp_inst, tex_cont, then per vertex: x, y, z, [u0 if texture], [v0 if texture and not uv_16_bit], base_col, [off_col if offset].
REQ-020 Words per vertex = 4 + texture*(uv_16_bit?1:2) + offset; total = 3 + vert_count*words_per_vertex.
REQ-021 States: IDLE, HDR0, HDR1, HDR2, VWAIT, VX, VY, VZ, VU, VV, VCOL, VOFF, DONE; optional states skipped per REQ-019.
REQ-022 Accepted start: next cycle in HDR0 with isp_vram_wr=1, isp_vram_addr=base_addr.
REQ-023 Each word state holds isp_vram_wr=1; address and data stable while isp_vram_wait=1; advances state and adds 4 to address only on acceptance.
REQ-024 After HDR2 and after each non-final vertex's last word: VWAIT, isp_vram_wr=0, vert_ready=1; when vert_valid=1 all fields latch into hold registers, proceed to VX next cycle.
REQ-025 vert_ready is 0 in every state other than VWAIT; vertex fields are never sampled elsewhere.
REQ-026 After final vertex's last word accepted: DONE for one cycle, done=1, busy=0 from that cycle, end_addr=final address+4, then IDLE.
REQ-027 start while busy is ignored, no effect on the current polygon.
REQ-028 Address wraps modulo 2^ADDR_W with no error.
REQ-029 Unstalled throughput: one word per cycle; one extra cycle per vertex for VWAIT when vert_valid already high.

Reset
REQ-030 reset_n low: state=IDLE; isp_vram_wr, vert_ready, busy, done =0; isp_vram_addr, isp_vram_dout, end_addr =0; takes effect immediately, mid-polygon included.
REQ-031 After reset release, no write issued until new accepted start; partially written polygon is abandoned.

Structure
REQ-032 Shared package pvr_param_pkg holds ISP_INST bit positions (TEXTURE=25, OFFSET=24, UV16=22), state encoding, and a words-per-vertex function shared with isp_parser.
REQ-033 No sub-module required; optional isp_vert_word_mux (combinational field select by state) permitted.

Verification
REQ-034 Untextured, no offset, 3 verts, base 0x00408C, isp_inst 0xC8000000, no stalls -> 15 words at 0x00408C..0x0040C4, done with end_addr=0x0040C8.
REQ-035 isp_inst 0xCB000000 (texture, offset, 32-bit UV), 3 verts, base 0 -> 24 words, vertex order x,y,z,u0,v0,col,off; end_addr=0x000060.
REQ-036 isp_inst 0xCAC00000 (texture, 16-bit UV), vert_count 4 -> 23 words, no v0 written; vert_count 1 -> 3 vertices, 18 words.
REQ-037 isp_vram_wait high 3 cycles on word 5 -> addr/data unchanged those cycles, completion 3 cycles later, same data.
REQ-038 vert_valid low 5 cycles in VWAIT -> vert_ready held, no writes; start pulsed while busy -> ignored.
REQ-039 reset_n low during word 7 -> all outputs 0 same cycle; after release no writes until start; next polygon correct from its base_addr.
